subcarrier_ctrl: RTL and testbench
==================================

// Module: subcarrier_ctrl
// PURPOSE
//  Per-line/per-field sequencer for the composite subcarrier NCO (40-bit phase accumulator + sine LUT).
//  Holds NTSC/PAL phase increments and mode, and applies them only at field boundaries.
//  Generates the colour-burst gate after each HSYNC, the PAL V-switch, and the phase-reload strobe.
//  Sits between the video timing generator and the NCO; drives its PHASE_INC and mode inputs.
// PARAMETERS
//  PHASE_W        40   phase increment / accumulator width
//  BREEZEWAY_CLKS 30   clocks from HSYNC trailing edge to burst start (>=1)
//  BURST_CLKS     120  burst gate length in clocks (>=1)
//  FIELD_RESYNC   1    1: pulse phase_load at every field start; 0: only when the applied config changes
// PORTS
//  clk           in   1        system clock
//  reset_n       in   1        async active-low reset
//  cfg_we        in   1        1-cycle write strobe for the cfg_* fields
//  cfg_mode      in   2        0=off, 1=NTSC, 2=PAL, 3=off (reserved)
//  cfg_inc_ntsc  in   PHASE_W  NTSC phase increment
//  cfg_inc_pal   in   PHASE_W  PAL phase increment (exact value, not derived from NTSC)
//  hsync         in   1        active-high horizontal sync level, synchronous to clk
//  vsync         in   1        active-high vertical sync level, synchronous to clk
//  phase_inc     out  PHASE_W  increment for the NCO for the applied mode
//  sc_mode       out  2        applied mode to the NCO (0/1/2)
//  phase_load    out  1        1-cycle strobe: NCO reloads its accumulator with phase_offset
//  phase_offset  out  8        LUT-index reload value
//  burst_gate    out  1        high during the burst window
//  pal_vswitch   out  1        PAL V-axis polarity for the current line
//  cfg_pending   out  1        a write is waiting for the next field boundary
// BEHAVIOUR
//  Reset: every output is 0. Shadow and applied registers are 0. FSM is IDLE.
//  Edge detect: hsync and vsync each have one register stage.
//   rise = in & ~q. fall = ~in & q. The edge is evaluated in the same cycle the input changes.
//  Config: cfg_we loads the shadow registers and sets cfg_pending.
//   On a vsync rise with cfg_pending=1, shadow copies to applied (visible next cycle) and cfg_pending clears.
//   cfg_we in the same cycle as a vsync rise: the older shadow value is applied.
//   The new write lands in the shadow and cfg_pending stays 1.
//   cfg_we while pending: overwrites the shadow (last write wins).
//  Mode map: applied mode 1 gives phase_inc=inc_ntsc, sc_mode=1.
//   Mode 2 gives inc_pal, sc_mode=2. Mode 0/3 gives phase_inc=0, sc_mode=0.
//   In off mode, burst_gate, pal_vswitch and phase_load are all forced 0.
//  phase_load: 1 cycle, the cycle after a vsync rise.
//   Fires if FIELD_RESYNC=1, or if the applied mode/increment changed at this rise.
//   phase_offset=8'h00 for NTSC. phase_offset=8'h20 (+45 deg) for PAL.
//  Line FSM states: IDLE, BREEZE, BURST, ACTIVE.
//   IDLE->BREEZE on hsync fall; the counter loads BREEZEWAY_CLKS-1.
//   BREEZE decrements; at 0 -> BURST, counter loads BURST_CLKS-1.
//   BURST: burst_gate=1 (registered); at 0 -> ACTIVE.
//   ACTIVE->IDLE on hsync rise.
//   hsync rise in BREEZE/BURST: abort to IDLE; burst_gate is 0 from the next cycle. It is never truncated to a glitch shorter than 1 clk.
//   vsync=1: burst suppressed. The FSM is held in IDLE and burst_gate=0.
//   Latency: burst_gate rises BREEZEWAY_CLKS+1 cycles after the hsync fall cycle.
//   It stays high for exactly BURST_CLKS cycles.
//  pal_vswitch: toggles on each hsync rise while the applied mode is 2. It clears on vsync rise.
//   Held 0 in other modes.
//  Mode change at a field boundary: the FSM is forced to IDLE.
//  Counters: 16-bit. Parameters must fit, checked by an elaboration assertion.
//  reset_n low mid-line: immediate async clear of all state. Operation resumes at the next hsync fall.
// STRUCTURE
//  Package subcarrier_pkg holds:
//   sc_mode_t enum (SC_OFF, SC_NTSC, SC_PAL).
//   line_state_t enum (IDLE, BREEZE, BURST, ACTIVE).
//   PHASE_W_DEF=40. PAL_OFFSET=8'h20.
//  Sub-module sc_edge_det (1-bit rise/fall detector with async active-low reset).
//   Instantiated for hsync and vsync.
//  The remainder (shadow/apply registers, FSM, counter) stays in subcarrier_ctrl.
// TESTING
//  1. Reset, no cfg, toggle hsync/vsync -> all outputs remain 0, FSM stays IDLE.
//  2. Write mode=1, inc_ntsc=40'h0123456789 -> cfg_pending=1, phase_inc=0.
//     Next vsync rise -> phase_inc=40'h0123456789, sc_mode=1, phase_load 1 cycle, offset 00.
//  3. NTSC, hsync low after 100 clk high, BREEZEWAY=30/BURST=120 ->
//     burst_gate rises 31 clks after the fall and lasts exactly 120 clks.
//  4. PAL, 4 lines -> pal_vswitch 1,0,1,0. vsync rise -> 0. phase_offset=8'h20.
//  5. hsync rises 50 clks into BURST -> burst_gate falls next cycle, FSM IDLE.
//     The next line gives a full 120-clk burst.
//  6. cfg_we coincident with vsync rise; reset_n pulsed mid-BURST ->
//     old shadow applied, pending stays 1; outputs clear immediately on reset.

Source files
------------

// File: rtl/subcarrier_pkg.sv
// ---------------------------------------------------------------------------
// subcarrier_pkg
//   Shared types and constants for the composite subcarrier sequencer.
//   sc_mode_t    : mode handed to the NCO (off / NTSC / PAL).
//   line_state_t : per-line burst sequencer states.
//   decode_mode  : maps the 2-bit register encoding onto sc_mode_t
//                  (the reserved code 3 behaves as off).
// ---------------------------------------------------------------------------
package subcarrier_pkg;

    typedef enum logic [1:0] {
        SC_OFF  = 2'd0,
        SC_NTSC = 2'd1,
        SC_PAL  = 2'd2
    } sc_mode_t;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        BREEZE = 2'd1,
        BURST  = 2'd2,
        ACTIVE = 2'd3
    } line_state_t;

    localparam int         PHASE_W_DEF = 40;
    localparam int         CNT_W       = 16;
    localparam logic [7:0] NTSC_OFFSET = 8'h00;
    // +45 degrees of the 256-entry sine LUT.
    localparam logic [7:0] PAL_OFFSET  = 8'h20;

    function automatic sc_mode_t decode_mode(input logic [1:0] raw);
        case (raw)
            2'd1:    return SC_NTSC;
            2'd2:    return SC_PAL;
            default: return SC_OFF;
        endcase
    endfunction

endpackage

// File: rtl/sc_edge_det.sv
// ---------------------------------------------------------------------------
// sc_edge_det
//   One-register rise/fall detector. The edge is flagged combinationally in
//   the same cycle the input changes, compared against last cycle's value.
// Ports:
//   clk      in   system clock
//   reset_n  in   async active-low reset (history register clears to 0)
//   sig_i    in   level to watch, synchronous to clk
//   rise_o   out  sig_i & ~previous
//   fall_o   out  ~sig_i & previous
// ---------------------------------------------------------------------------
module sc_edge_det (
    input  logic clk,
    input  logic reset_n,
    input  logic sig_i,
    output logic rise_o,
    output logic fall_o
);

    logic sig_q;

    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples pre-edge values regardless of process evaluation order.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            sig_q <= 1'b0;
        end else begin
            sig_q <= sig_i;
        end
    end

    assign rise_o = sig_i & ~sig_q;
    assign fall_o = ~sig_i & sig_q;

endmodule

// File: rtl/subcarrier_ctrl.sv
// ---------------------------------------------------------------------------
// subcarrier_ctrl
//   Per-line / per-field sequencer for the composite subcarrier NCO.
//   Software writes land in shadow registers and are applied only at a
//   field boundary (vsync rise). The line FSM times the colour-burst gate
//   after each HSYNC; PAL V-switch and the NCO phase-reload strobe are
//   generated here as well.
// Ports:
//   clk            in   system clock
//   reset_n        in   async active-low reset
//   cfg_we         in   1-cycle write strobe for the cfg_* fields
//   cfg_mode       in   0=off, 1=NTSC, 2=PAL, 3=off (reserved)
//   cfg_inc_ntsc   in   NTSC phase increment
//   cfg_inc_pal    in   PAL phase increment
//   hsync / vsync  in   active-high sync levels, synchronous to clk
//   phase_inc      out  NCO increment for the applied mode (0 when off)
//   sc_mode        out  applied mode (0/1/2)
//   phase_load     out  1-cycle accumulator reload strobe
//   phase_offset   out  LUT-index reload value
//   burst_gate     out  high for the burst window of each line
//   pal_vswitch    out  PAL V-axis polarity of the current line
//   cfg_pending    out  a shadow write awaits the next field boundary
// ---------------------------------------------------------------------------
module subcarrier_ctrl
    import subcarrier_pkg::*;
#(
    parameter int PHASE_W        = PHASE_W_DEF,
    parameter int BREEZEWAY_CLKS = 30,
    parameter int BURST_CLKS     = 120,
    parameter bit FIELD_RESYNC   = 1'b1
) (
    input  logic               clk,
    input  logic               reset_n,
    input  logic               cfg_we,
    input  logic [1:0]         cfg_mode,
    input  logic [PHASE_W-1:0] cfg_inc_ntsc,
    input  logic [PHASE_W-1:0] cfg_inc_pal,
    input  logic               hsync,
    input  logic               vsync,
    output logic [PHASE_W-1:0] phase_inc,
    output logic [1:0]         sc_mode,
    output logic               phase_load,
    output logic [7:0]         phase_offset,
    output logic               burst_gate,
    output logic               pal_vswitch,
    output logic               cfg_pending
);

    // ------------------------------------------------------------------
    // Elaboration checks: both window lengths must load into the counter.
    // ------------------------------------------------------------------
    if (BREEZEWAY_CLKS < 1 || BREEZEWAY_CLKS > (1 << CNT_W)) begin : g_bad_breezeway
        $error("subcarrier_ctrl: BREEZEWAY_CLKS out of range for the line counter");
    end
    if (BURST_CLKS < 1 || BURST_CLKS > (1 << CNT_W)) begin : g_bad_burst
        $error("subcarrier_ctrl: BURST_CLKS out of range for the line counter");
    end
    if (PHASE_W < 1) begin : g_bad_phase_w
        $error("subcarrier_ctrl: PHASE_W must be at least 1");
    end

    // Counter counts down to 0, so it is loaded with length-1.
    localparam logic [CNT_W-1:0] BREEZE_LOAD = CNT_W'(BREEZEWAY_CLKS - 1);
    localparam logic [CNT_W-1:0] BURST_LOAD  = CNT_W'(BURST_CLKS - 1);

    // ------------------------------------------------------------------
    // Sync edge detection
    // ------------------------------------------------------------------
    logic hs_rise, hs_fall;
    logic vs_rise, vs_fall_unused;

    sc_edge_det u_hs_edge (
        .clk     (clk),
        .reset_n (reset_n),
        .sig_i   (hsync),
        .rise_o  (hs_rise),
        .fall_o  (hs_fall)
    );

    sc_edge_det u_vs_edge (
        .clk     (clk),
        .reset_n (reset_n),
        .sig_i   (vsync),
        .rise_o  (vs_rise),
        .fall_o  (vs_fall_unused)
    );

    // ------------------------------------------------------------------
    // Shadow / applied configuration
    // ------------------------------------------------------------------
    sc_mode_t           shadow_mode_q, shadow_mode_d;
    logic [PHASE_W-1:0] shadow_ntsc_q, shadow_ntsc_d;
    logic [PHASE_W-1:0] shadow_pal_q,  shadow_pal_d;
    logic               pending_q,     pending_d;

    sc_mode_t           applied_mode_q, applied_mode_d;
    logic [PHASE_W-1:0] applied_ntsc_q, applied_ntsc_d;
    logic [PHASE_W-1:0] applied_pal_q,  applied_pal_d;

    logic               phase_load_q, phase_load_d;
    logic               vswitch_q,    vswitch_d;

    logic               apply_now;
    logic               cfg_changed;
    logic [PHASE_W-1:0] shadow_inc;
    logic [PHASE_W-1:0] applied_inc;

    assign apply_now = vs_rise & pending_q;

    // Effective increment of a configuration: what the NCO would actually
    // see. Used both for the output and for detecting a real change.
    // NOTE: every combinational output gets a default first so no path
    // leaves it unassigned (which would infer a latch).
    always_comb begin
        shadow_inc  = '0;
        applied_inc = '0;
        case (shadow_mode_q)
            SC_NTSC: shadow_inc = shadow_ntsc_q;
            SC_PAL:  shadow_inc = shadow_pal_q;
            default: shadow_inc = '0;
        endcase
        case (applied_mode_q)
            SC_NTSC: applied_inc = applied_ntsc_q;
            SC_PAL:  applied_inc = applied_pal_q;
            default: applied_inc = '0;
        endcase
    end

    assign cfg_changed = (shadow_mode_q != applied_mode_q) || (shadow_inc != applied_inc);

    // Apply reads the shadow before this cycle's write lands, so a write
    // coincident with the boundary stays pending for the next field.
    always_comb begin
        shadow_mode_d  = shadow_mode_q;
        shadow_ntsc_d  = shadow_ntsc_q;
        shadow_pal_d   = shadow_pal_q;
        pending_d      = pending_q;
        applied_mode_d = applied_mode_q;
        applied_ntsc_d = applied_ntsc_q;
        applied_pal_d  = applied_pal_q;

        if (apply_now) begin
            applied_mode_d = shadow_mode_q;
            applied_ntsc_d = shadow_ntsc_q;
            applied_pal_d  = shadow_pal_q;
            pending_d      = 1'b0;
        end
        if (cfg_we) begin
            shadow_mode_d = decode_mode(cfg_mode);
            shadow_ntsc_d = cfg_inc_ntsc;
            shadow_pal_d  = cfg_inc_pal;
            pending_d     = 1'b1;
        end
    end

    // Reload strobe lands the cycle after the vsync rise, together with
    // the newly applied configuration.
    assign phase_load_d = vs_rise & (FIELD_RESYNC | (apply_now & cfg_changed));

    // V-switch toggles per line in PAL only; a new field restarts it at 0.
    always_comb begin
        vswitch_d = vswitch_q;
        if (vs_rise || applied_mode_q != SC_PAL) begin
            vswitch_d = 1'b0;
        end else if (hs_rise) begin
            vswitch_d = ~vswitch_q;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            shadow_mode_q  <= SC_OFF;
            shadow_ntsc_q  <= '0;
            shadow_pal_q   <= '0;
            pending_q      <= 1'b0;
            applied_mode_q <= SC_OFF;
            applied_ntsc_q <= '0;
            applied_pal_q  <= '0;
            phase_load_q   <= 1'b0;
            vswitch_q      <= 1'b0;
        end else begin
            shadow_mode_q  <= shadow_mode_d;
            shadow_ntsc_q  <= shadow_ntsc_d;
            shadow_pal_q   <= shadow_pal_d;
            pending_q      <= pending_d;
            applied_mode_q <= applied_mode_d;
            applied_ntsc_q <= applied_ntsc_d;
            applied_pal_q  <= applied_pal_d;
            phase_load_q   <= phase_load_d;
            vswitch_q      <= vswitch_d;
        end
    end

    // ------------------------------------------------------------------
    // Line FSM: state register / next state / outputs
    // ------------------------------------------------------------------
    line_state_t       state_q, state_d;
    logic [CNT_W-1:0]  cnt_q,   cnt_d;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= IDLE;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    // vsync high (which includes every field boundary, and therefore every
    // mode change) or an off mode parks the FSM in IDLE.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        if (vsync || applied_mode_q == SC_OFF) begin
            state_d = IDLE;
            cnt_d   = '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (hs_fall) begin
                        state_d = BREEZE;
                        cnt_d   = BREEZE_LOAD;
                    end
                end
                BREEZE: begin
                    if (hs_rise) begin
                        state_d = IDLE;
                    end else if (cnt_q == '0) begin
                        state_d = BURST;
                        cnt_d   = BURST_LOAD;
                    end else begin
                        cnt_d = cnt_q - 1'b1;
                    end
                end
                BURST: begin
                    if (hs_rise) begin
                        state_d = IDLE;
                    end else if (cnt_q == '0) begin
                        state_d = ACTIVE;
                    end else begin
                        cnt_d = cnt_q - 1'b1;
                    end
                end
                ACTIVE: begin
                    if (hs_rise) begin
                        state_d = IDLE;
                    end
                end
                default: begin
                    state_d = IDLE;
                    cnt_d   = '0;
                end
            endcase
        end
    end

    // Gate decodes the registered state, so an abort drops it cleanly on
    // the following cycle and it can never be shorter than one clock.
    always_comb begin
        burst_gate = 1'b0;
        if (state_q == BURST && applied_mode_q != SC_OFF) begin
            burst_gate = 1'b1;
        end
    end

    // ------------------------------------------------------------------
    // NCO-facing outputs
    // ------------------------------------------------------------------
    assign phase_inc    = applied_inc;
    assign sc_mode      = applied_mode_q;
    assign phase_offset = (applied_mode_q == SC_PAL) ? PAL_OFFSET : NTSC_OFFSET;
    assign phase_load   = phase_load_q & (applied_mode_q != SC_OFF);
    assign pal_vswitch  = vswitch_q & (applied_mode_q == SC_PAL);
    assign cfg_pending  = pending_q;

endmodule

// File: tb/tb_subcarrier_ctrl.sv
// ---------------------------------------------------------------------------
// tb_subcarrier_ctrl
//   Directed sequences, a table of mode-map vectors and randomized lines.
//   A behavioural model (burst window measured from the hsync fall time,
//   line-parity counter, shadow/applied config) is checked every cycle.
// ---------------------------------------------------------------------------
module tb_subcarrier_ctrl;

    localparam int PW = 40;
    localparam int B  = 30;
    localparam int BU = 120;

    logic          clk = 1'b0;
    logic          reset_n;
    logic          cfg_we;
    logic [1:0]    cfg_mode;
    logic [PW-1:0] cfg_inc_ntsc;
    logic [PW-1:0] cfg_inc_pal;
    logic          hsync;
    logic          vsync;
    logic [PW-1:0] phase_inc;
    logic [1:0]    sc_mode;
    logic          phase_load;
    logic [7:0]    phase_offset;
    logic          burst_gate;
    logic          pal_vswitch;
    logic          cfg_pending;

    int n_tests = 0;
    int n_fail  = 0;

    subcarrier_ctrl #(
        .PHASE_W        (PW),
        .BREEZEWAY_CLKS (B),
        .BURST_CLKS     (BU),
        .FIELD_RESYNC   (1'b1)
    ) dut (
        .clk          (clk),
        .reset_n      (reset_n),
        .cfg_we       (cfg_we),
        .cfg_mode     (cfg_mode),
        .cfg_inc_ntsc (cfg_inc_ntsc),
        .cfg_inc_pal  (cfg_inc_pal),
        .hsync        (hsync),
        .vsync        (vsync),
        .phase_inc    (phase_inc),
        .sc_mode      (sc_mode),
        .phase_load   (phase_load),
        .phase_offset (phase_offset),
        .burst_gate   (burst_gate),
        .pal_vswitch  (pal_vswitch),
        .cfg_pending  (cfg_pending)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    function automatic logic [1:0] eff_mode(input logic [1:0] m);
        return (m == 2'd1 || m == 2'd2) ? m : 2'd0;
    endfunction

    function automatic logic [PW-1:0] eff_inc(input logic [1:0] m, input logic [PW-1:0] n,
                                              input logic [PW-1:0] p);
        if (m == 2'd1) return n;
        if (m == 2'd2) return p;
        return '0;
    endfunction

    logic [1:0]    m_sh_mode = '0, m_ap_mode = '0;
    logic [PW-1:0] m_sh_ntsc = '0, m_sh_pal = '0, m_ap_ntsc = '0, m_ap_pal = '0;
    bit            m_pending = 0, m_load_req = 0, m_alive = 0, m_hs_prev = 0, m_vs_prev = 0;
    int            m_pal_lines = 0;
    longint        m_cyc = 0, m_fall = 0;

    always @(posedge clk or negedge reset_n) begin : model
        bit hs_r, hs_f, vs_r, changed;
        if (!reset_n) begin
            m_sh_mode = '0; m_ap_mode = '0;
            m_sh_ntsc = '0; m_sh_pal = '0; m_ap_ntsc = '0; m_ap_pal = '0;
            m_pending = 0; m_load_req = 0; m_alive = 0; m_hs_prev = 0; m_vs_prev = 0;
            m_pal_lines = 0; m_cyc = 0; m_fall = 0;
        end else begin
            hs_r = hsync && !m_hs_prev;
            hs_f = !hsync && m_hs_prev;
            vs_r = vsync && !m_vs_prev;
            // A line is live from its hsync fall until anything that kills it.
            if (hs_r || vsync || eff_mode(m_ap_mode) == 2'd0) m_alive = 0;
            else if (hs_f) begin m_alive = 1; m_fall = m_cyc; end
            // Lines counted since field start, in PAL only.
            if (vs_r || eff_mode(m_ap_mode) != 2'd2) m_pal_lines = 0;
            else if (hs_r) m_pal_lines++;
            m_load_req = 0;
            if (vs_r) begin
                changed = m_pending &&
                          (eff_mode(m_sh_mode) != eff_mode(m_ap_mode) ||
                           eff_inc(m_sh_mode, m_sh_ntsc, m_sh_pal) != eff_inc(m_ap_mode, m_ap_ntsc, m_ap_pal));
                m_load_req = 1'b1 || changed;
                if (m_pending) begin
                    m_ap_mode = m_sh_mode; m_ap_ntsc = m_sh_ntsc; m_ap_pal = m_sh_pal;
                    m_pending = 0;
                end
            end
            if (cfg_we) begin
                m_sh_mode = cfg_mode; m_sh_ntsc = cfg_inc_ntsc; m_sh_pal = cfg_inc_pal;
                m_pending = 1;
            end
            m_hs_prev = hsync;
            m_vs_prev = vsync;
            m_cyc++;
        end
    end

    always @(negedge clk) begin : scoreboard
        logic [1:0] em;
        longint     dt;
        if (reset_n) begin
            em = eff_mode(m_ap_mode);
            dt = m_cyc - m_fall;
            check("m_phase_inc", 64'(phase_inc), 64'(eff_inc(m_ap_mode, m_ap_ntsc, m_ap_pal)));
            check("m_sc_mode", 64'(sc_mode), 64'(em));
            check("m_phase_offset", 64'(phase_offset), 64'((em == 2'd2) ? 8'h20 : 8'h00));
            check("m_phase_load", 64'(phase_load), 64'(m_load_req && em != 2'd0));
            check("m_burst_gate", 64'(burst_gate), 64'(m_alive && dt >= B + 1 && dt <= B + BU));
            check("m_pal_vswitch", 64'(pal_vswitch), 64'(m_pal_lines[0] && em == 2'd2));
            check("m_cfg_pending", 64'(cfg_pending), 64'(m_pending));
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic cyc(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic write_cfg(input logic [1:0] m, input logic [PW-1:0] n, input logic [PW-1:0] p);
        cfg_we = 1'b1; cfg_mode = m; cfg_inc_ntsc = n; cfg_inc_pal = p;
        cyc(1);
        cfg_we = 1'b0;
    endtask

    task automatic vs_pulse();
        vsync = 1'b1;
        cyc(3);
        vsync = 1'b0;
        cyc(2);
    endtask

    task automatic line(input int hi, input int lo);
        hsync = 1'b1;
        cyc(hi);
        hsync = 1'b0;
        cyc(lo);
    endtask

    // Drives hsync low for n cycles; reports the first burst cycle relative
    // to the fall cycle and the number of burst cycles seen.
    task automatic run_low(input int n, output int rise_at, output int width);
        rise_at = -1;
        width   = 0;
        hsync   = 1'b0;
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            if (burst_gate) begin
                if (rise_at < 0) rise_at = i;
                width++;
            end
            @(posedge clk);
            #1;
        end
    endtask

    typedef struct {
        logic [1:0]    mode;
        logic [PW-1:0] ntsc;
        logic [PW-1:0] pal;
        logic [PW-1:0] exp_inc;
        logic [1:0]    exp_mode;
        logic [7:0]    exp_off;
        logic          exp_load;
    } vec_t;

    vec_t vecs[5];
    int   r_at, wid;

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        reset_n = 1'b0; cfg_we = 1'b0; cfg_mode = '0; cfg_inc_ntsc = '0; cfg_inc_pal = '0;
        hsync = 1'b0; vsync = 1'b0;

        vecs[0] = '{2'd1, 40'hAB_CDEF_0123, 40'h11_2233_4455, 40'hAB_CDEF_0123, 2'd1, 8'h00, 1'b1};
        vecs[1] = '{2'd2, 40'hAB_CDEF_0123, 40'h11_2233_4455, 40'h11_2233_4455, 2'd2, 8'h20, 1'b1};
        vecs[2] = '{2'd3, 40'h55_5555_5555, 40'h66_6666_6666, 40'h0,            2'd0, 8'h00, 1'b0};
        vecs[3] = '{2'd0, 40'h77_7777_7777, 40'h88_8888_8888, 40'h0,            2'd0, 8'h00, 1'b0};
        vecs[4] = '{2'd2, 40'h00_0000_0001, 40'hFF_FFFF_FFFF, 40'hFF_FFFF_FFFF, 2'd2, 8'h20, 1'b1};

        cyc(3);
        reset_n = 1'b1;
        cyc(1);

        // 1: no config, sync activity -> everything stays quiet
        check("t1_reset_outputs", 64'({phase_inc, sc_mode, phase_load, phase_offset,
                                       burst_gate, pal_vswitch, cfg_pending}), 64'(0));
        line(20, 180);
        vs_pulse();
        line(20, 180);
        check("t1_after_sync", 64'({phase_inc, sc_mode, phase_load, phase_offset,
                                    burst_gate, pal_vswitch, cfg_pending}), 64'(0));

        // 2: NTSC write waits for the field boundary
        write_cfg(2'd1, 40'h0123456789, 40'h0);
        check("t2_pending", 64'(cfg_pending), 64'(1));
        check("t2_inc_before", 64'(phase_inc), 64'(0));
        vsync = 1'b1;
        cyc(1);
        check("t2_inc_applied", 64'(phase_inc), 64'h0123456789);
        check("t2_sc_mode", 64'(sc_mode), 64'(1));
        check("t2_load_pulse", 64'(phase_load), 64'(1));
        check("t2_offset", 64'(phase_offset), 64'h00);
        cyc(1);
        check("t2_load_single", 64'(phase_load), 64'(0));
        check("t2_pending_clr", 64'(cfg_pending), 64'(0));
        vsync = 1'b0;
        cyc(2);

        // mode map table
        foreach (vecs[i]) begin
            write_cfg(vecs[i].mode, vecs[i].ntsc, vecs[i].pal);
            vsync = 1'b1;
            cyc(1);
            check($sformatf("tab%0d_inc", i), 64'(phase_inc), 64'(vecs[i].exp_inc));
            check($sformatf("tab%0d_mode", i), 64'(sc_mode), 64'(vecs[i].exp_mode));
            check($sformatf("tab%0d_off", i), 64'(phase_offset), 64'(vecs[i].exp_off));
            check($sformatf("tab%0d_load", i), 64'(phase_load), 64'(vecs[i].exp_load));
            cyc(2);
            vsync = 1'b0;
            cyc(2);
        end

        // 3: NTSC burst timing
        write_cfg(2'd1, 40'h0123456789, 40'h0);
        vs_pulse();
        hsync = 1'b1;
        cyc(100);
        run_low(300, r_at, wid);
        check("t3_latency", 64'(r_at), 64'(B + 1));
        check("t3_width", 64'(wid), 64'(BU));

        // 4: PAL V-switch sequence
        write_cfg(2'd2, 40'h0, 40'h0A5A5A5A5A);
        vs_pulse();
        check("t4_offset", 64'(phase_offset), 64'h20);
        check("t4_vsw_start", 64'(pal_vswitch), 64'(0));
        for (int i = 0; i < 4; i++) begin
            line(10, 20);
            check($sformatf("t4_vsw_line%0d", i), 64'(pal_vswitch), 64'(i % 2 == 0));
        end
        line(10, 20);
        check("t4_vsw_line4", 64'(pal_vswitch), 64'(1));
        vs_pulse();
        check("t4_vsw_vsync_clr", 64'(pal_vswitch), 64'(0));

        // 5: hsync rise 50 clocks into the burst aborts it
        hsync = 1'b1;
        cyc(10);
        run_low(B + 1 + 50, r_at, wid);
        check("t5_latency", 64'(r_at), 64'(B + 1));
        check("t5_partial", 64'(wid), 64'(50));
        hsync = 1'b1;
        check("t5_gate_at_rise", 64'(burst_gate), 64'(1));
        cyc(1);
        check("t5_gate_after", 64'(burst_gate), 64'(0));
        cyc(9);
        run_low(200, r_at, wid);
        check("t5_next_latency", 64'(r_at), 64'(B + 1));
        check("t5_next_width", 64'(wid), 64'(BU));

        // 6: write coincident with the field boundary, then reset mid-burst
        write_cfg(2'd1, 40'h1111111111, 40'h0);
        cyc(2);
        cfg_we = 1'b1; cfg_mode = 2'd2; cfg_inc_pal = 40'h2222222222;
        vsync = 1'b1;
        cyc(1);
        cfg_we = 1'b0;
        check("t6_old_mode", 64'(sc_mode), 64'(1));
        check("t6_old_inc", 64'(phase_inc), 64'h1111111111);
        check("t6_still_pending", 64'(cfg_pending), 64'(1));
        cyc(2);
        vsync = 1'b0;
        cyc(2);
        hsync = 1'b1;
        cyc(10);
        hsync = 1'b0;
        cyc(B + 10);
        check("t6_in_burst", 64'(burst_gate), 64'(1));
        #2;
        reset_n = 1'b0;
        #1;
        check("t6_async_clear", 64'({phase_inc, sc_mode, phase_load, phase_offset,
                                     burst_gate, pal_vswitch, cfg_pending}), 64'(0));
        repeat (2) @(posedge clk);
        #1;
        reset_n = 1'b1;
        cyc(2);
        write_cfg(2'd1, 40'h0123456789, 40'h0);
        vs_pulse();
        hsync = 1'b1;
        cyc(5);
        run_low(200, r_at, wid);
        check("t6_resume_latency", 64'(r_at), 64'(B + 1));
        check("t6_resume_width", 64'(wid), 64'(BU));

        // randomized lines, config writes and fields against the model
        for (int ln = 0; ln < 60; ln++) begin
            bit do_cfg, do_vs;
            do_cfg = ($urandom_range(0, 2) == 0);
            do_vs  = ($urandom_range(0, 3) == 0);
            if (do_cfg) begin
                cfg_we = 1'b1;
                cfg_mode = 2'($urandom_range(0, 3));
                cfg_inc_ntsc = {8'($urandom), 32'($urandom)};
                cfg_inc_pal  = {8'($urandom), 32'($urandom)};
            end
            if (do_vs) vsync = 1'b1;
            hsync = 1'b1;
            cyc(1);
            cfg_we = 1'b0;
            cyc($urandom_range(1, 3));
            vsync = 1'b0;
            cyc($urandom_range(2, 10));
            hsync = 1'b0;
            cyc($urandom_range(10, 100));
            if ($urandom_range(0, 7) == 0) begin
                vsync = 1'b1;
                cyc(2);
                vsync = 1'b0;
            end
            cyc($urandom_range(20, 110));
        end
        cyc(5);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
